// File: rtl/serial_adder_n.sv
// -----------------------------------------------------------------------------
// serial_adder_n
//
// Purpose:
//   Multi-cycle adder. It adds two WIDTH-bit operands and a carry-in over
//   N = WIDTH/DIGIT clock cycles. Each cycle it processes DIGIT bits, starting
//   at the LSB, through a chain of DIGIT full-adder cells plus a registered
//   carry. A start/busy/done handshake controls it. The last completed result
//   (sum, cout, ovf) stays stable until the next operation completes.
//
// Parameters:
//   WIDTH : operand and sum width in bits (>= 1)
//   DIGIT : bits added per clock cycle; must divide WIDTH exactly
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset; aborts any operation
//   start in   request an add; sampled only in IDLE
//   a     in   operand A, captured on the accepted start edge
//   b     in   operand B, captured on the accepted start edge
//   cin   in   carry-in, captured on the accepted start edge
//   sub   in   (only with SERIAL_ADDER_N_SUB_EN) 1 = compute a - b
//   busy  out  high while the RUN state is active (N cycles)
//   done  out  one-cycle pulse; the result registers were just updated
//   sum   out  last completed sum (modulo 2^WIDTH)
//   cout  out  carry out of the MSB of the last completed sum
//   ovf   out  signed overflow of the last completed sum
//
// Optional feature:
//   Define SERIAL_ADDER_N_SUB_EN to add the 'sub' input. When sub=1 the block
//   computes a + ~b + 1, ignores cin, and cout=1 means "no borrow".
// -----------------------------------------------------------------------------
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_N_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);

  // Reject configurations that cannot be split into whole digits.
  generate
    if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
      $error("serial_adder_n: WIDTH must be >= 1 and an exact multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  // Operand shift registers, partial sum, running carry and digit counter.
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_psum;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  // Result registers that the outputs present.
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  // Control decode.
  logic               w_accept;
  logic               w_last;

  // Digit datapath.
  logic [DIGIT-1:0]       w_dsum;
  logic                   w_dcarry;
  logic                   w_cmsb;
  logic [WIDTH+DIGIT-1:0] w_cat;
  logic [WIDTH-1:0]       w_psum_nxt;
  logic                   w_unused_psum;

  // Operand/carry values loaded on an accepted start.
  logic [WIDTH-1:0]   w_b_in;
  logic               w_c_in;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_last = (r_cnt == LAST_DIGIT);
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // start is ignored here; always go back to IDLE.
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand conditioning at capture time
  // ---------------------------------------------------------------------------
  always_comb begin
`ifdef SERIAL_ADDER_N_SUB_EN
    // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
    w_b_in = sub ? ~b : b;
    w_c_in = sub ? 1'b1 : cin;
`else
    w_b_in = b;
    w_c_in = cin;
`endif
  end

  // ---------------------------------------------------------------------------
  // Ripple chain of DIGIT full-adder cells fed from the shift-register LSBs
  // ---------------------------------------------------------------------------
  always_comb begin
    logic v_c;
    v_c      = r_carry;
    w_cmsb   = r_carry;
    w_dsum   = '0;
    for (int i = 0; i < DIGIT; i++) begin
      // The top cell of the last digit handles bit WIDTH-1. Its carry-in is
      // the carry into the MSB that the overflow flag needs. For WIDTH=1 this
      // carry is the captured carry-in.
      if (i == DIGIT - 1) begin
        w_cmsb = v_c;
      end
      w_dsum[i] = r_a[i] ^ r_b[i] ^ v_c;
      v_c       = (r_a[i] & r_b[i]) | (v_c & (r_a[i] ^ r_b[i]));
    end
    w_dcarry = v_c;
  end

  // New digit enters at the MSB end; the lowest DIGIT bits shift out.
  assign w_cat         = {w_dsum, r_psum};
  assign w_psum_nxt    = w_cat[WIDTH+DIGIT-1:DIGIT];
  assign w_unused_psum = ^w_cat[DIGIT-1:0];

  // ---------------------------------------------------------------------------
  // State, datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_accept) begin
        r_a     <= a;
        r_b     <= w_b_in;
        r_carry <= w_c_in;
        r_psum  <= '0;
        r_cnt   <= '0;
      end

      if (r_state == S_RUN) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_psum  <= w_psum_nxt;
        r_carry <= w_dcarry;
        r_cnt   <= r_cnt + 1'b1;
        // The result registers change only on the edge that finishes the
        // last digit, so the previous result holds through RUN and IDLE.
        if (w_last) begin
          r_sum  <= w_psum_nxt;
          r_cout <= w_dcarry;
          r_ovf  <= w_cmsb ^ w_dcarry;
        end
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_n.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_n
//
// Directed self-checking bench for serial_adder_n. It uses two instances:
// WIDTH=8/DIGIT=1 (u_dut1) and WIDTH=8/DIGIT=4 (u_dut4). The expected values
// are worked out by hand. With SERIAL_ADDER_N_SUB_EN defined, the bench also
// drives the sub port and runs the subtraction vectors.
// -----------------------------------------------------------------------------
module tb_serial_adder_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1;
  logic       start4;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
`ifdef SERIAL_ADDER_N_SUB_EN
  logic       sub;
`endif

  logic       busy1, done1, cout1, ovf1;
  logic [7:0] sum1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_adder_n #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_N_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy1),
    .done  (done1),
    .sum   (sum1),
    .cout  (cout1),
    .ovf   (ovf1)
  );

  serial_adder_n #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .start (start4),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_N_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4),
    .ovf   (ovf4)
  );

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start one operation on u_dut1 and observe 12 cycles after the start edge.
  // lat is the observation index at which done was first seen (-1 = never).
  task automatic run1(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                      output int lat, output int nbusy, output int ndone);
    a      = ta;
    b      = tb_v;
    cin    = tc;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat    = -1;
    nbusy  = 0;
    ndone  = 0;
    for (int k = 0; k < 12; k++) begin
      if (busy1) nbusy++;
      if (done1) begin
        ndone++;
        if (lat < 0) lat = k;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0;
    tick();
    tick();
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy1 got=%b want=0", busy1); end
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL reset_done1 got=%b want=0", done1); end
    total++; if (sum1 !== 8'h00) begin bad++; $display("FAIL reset_sum1 got=%h want=00", sum1); end
    total++; if (cout1 !== 1'b0) begin bad++; $display("FAIL reset_cout1 got=%b want=0", cout1); end
    total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL reset_ovf1 got=%b want=0", ovf1); end
    total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL reset_busy4 got=%b want=0", busy4); end
    total++; if (sum4 !== 8'h00) begin bad++; $display("FAIL reset_sum4 got=%h want=00", sum4); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add_basic();
    int lat, nb, nd;
    run1(8'h5A, 8'h3C, 1'b0, lat, nb, nd);
    total++; if (lat !== 8) begin bad++; $display("FAIL basic_latency got=%0d want=8", lat); end
    total++; if (nb !== 8) begin bad++; $display("FAIL basic_busy_cycles got=%0d want=8", nb); end
    total++; if (nd !== 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", nd); end
    total++; if (sum1 !== 8'h96) begin bad++; $display("FAIL basic_sum got=%h want=96", sum1); end
    total++; if (cout1 !== 1'b0) begin bad++; $display("FAIL basic_cout got=%b want=0", cout1); end
    total++; if (ovf1 !== 1'b1) begin bad++; $display("FAIL basic_ovf got=%b want=1", ovf1); end
  endtask

  task automatic test_carry();
    int lat, nb, nd;
    run1(8'hFF, 8'h01, 1'b0, lat, nb, nd);
    total++; if (sum1 !== 8'h00) begin bad++; $display("FAIL carry1_sum got=%h want=00", sum1); end
    total++; if (cout1 !== 1'b1) begin bad++; $display("FAIL carry1_cout got=%b want=1", cout1); end
    total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL carry1_ovf got=%b want=0", ovf1); end
    run1(8'hFF, 8'h00, 1'b1, lat, nb, nd);
    total++; if (sum1 !== 8'h00) begin bad++; $display("FAIL carry2_sum got=%h want=00", sum1); end
    total++; if (cout1 !== 1'b1) begin bad++; $display("FAIL carry2_cout got=%b want=1", cout1); end
    total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL carry2_ovf got=%b want=0", ovf1); end
  endtask

  task automatic test_digit4();
    int lat, nb, nd;
    a = 8'hFF; b = 8'hFF; cin = 1'b1;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = -1; nb = 0; nd = 0;
    for (int k = 0; k < 8; k++) begin
      if (busy4) nb++;
      if (done4) begin
        nd++;
        if (lat < 0) lat = k;
      end
      tick();
    end
    total++; if (lat !== 2) begin bad++; $display("FAIL d4_latency got=%0d want=2", lat); end
    total++; if (nb !== 2) begin bad++; $display("FAIL d4_busy_cycles got=%0d want=2", nb); end
    total++; if (nd !== 1) begin bad++; $display("FAIL d4_done_count got=%0d want=1", nd); end
    total++; if (sum4 !== 8'hFF) begin bad++; $display("FAIL d4_sum got=%h want=ff", sum4); end
    total++; if (cout4 !== 1'b1) begin bad++; $display("FAIL d4_cout got=%b want=1", cout4); end
    total++; if (ovf4 !== 1'b0) begin bad++; $display("FAIL d4_ovf got=%b want=0", ovf4); end
  endtask

  task automatic test_ignore_start();
    int nb, nd, lat, nb2, nd2;
    // The previous result is 0x00 (from test_carry).
    a = 8'h5A; b = 8'h3C; cin = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    nb = 0; nd = 0;
    for (int k = 0; k < 12; k++) begin
      if (busy1) nb++;
      if (done1) nd++;
      if (k == 4) begin
        total++;
        if (sum1 !== 8'h00) begin bad++; $display("FAIL hold_during_run got=%h want=00", sum1); end
      end
      start1 = 1'b0;
      if (k == 2) begin a = 8'h01; b = 8'h01; start1 = 1'b1; end
      if (k == 8) begin a = 8'h11; b = 8'h22; start1 = 1'b1; end
      tick();
    end
    start1 = 1'b0;
    total++; if (nd !== 1) begin bad++; $display("FAIL ignore_done_count got=%0d want=1", nd); end
    total++; if (nb !== 8) begin bad++; $display("FAIL ignore_busy_cycles got=%0d want=8", nb); end
    total++; if (sum1 !== 8'h96) begin bad++; $display("FAIL ignore_sum got=%h want=96", sum1); end
    run1(8'h11, 8'h22, 1'b0, lat, nb2, nd2);
    total++; if (lat !== 8) begin bad++; $display("FAIL next_start_latency got=%0d want=8", lat); end
    total++; if (sum1 !== 8'h33) begin bad++; $display("FAIL next_start_sum got=%h want=33", sum1); end
  endtask

  task automatic test_reset_abort();
    int lat, nb, nd;
    run1(8'h5A, 8'h3C, 1'b0, lat, nb, nd);
    total++; if (sum1 !== 8'h96) begin bad++; $display("FAIL abort_pre_sum got=%h want=96", sum1); end
    a = 8'h01; b = 8'h01; cin = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    // Third RUN cycle: the next edge applies reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy1); end
    total++; if (done1 !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done1); end
    total++; if (sum1 !== 8'h00) begin bad++; $display("FAIL abort_sum got=%h want=00", sum1); end
    total++; if (cout1 !== 1'b0) begin bad++; $display("FAIL abort_cout got=%b want=0", cout1); end
    total++; if (ovf1 !== 1'b1 ^ 1'b1) begin bad++; $display("FAIL abort_ovf got=%b want=0", ovf1); end
    nd = 0;
    for (int k = 0; k < 10; k++) begin
      if (done1) nd++;
      tick();
    end
    total++; if (nd !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", nd); end
    // Reset and start in the same cycle: reset wins.
    rst = 1'b1; start1 = 1'b1;
    tick();
    rst = 1'b0; start1 = 1'b0;
    total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL rst_beats_start got=%b want=0", busy1); end
    run1(8'h01, 8'h01, 1'b0, lat, nb, nd);
    total++; if (sum1 !== 8'h02) begin bad++; $display("FAIL after_abort_sum got=%h want=02", sum1); end
    total++; if (lat !== 8) begin bad++; $display("FAIL after_abort_latency got=%0d want=8", lat); end
  endtask

`ifdef SERIAL_ADDER_N_SUB_EN
  task automatic test_sub();
    int lat, nb, nd;
    sub = 1'b1;
    run1(8'h10, 8'h20, 1'b0, lat, nb, nd);
    total++; if (sum1 !== 8'hF0) begin bad++; $display("FAIL sub1_sum got=%h want=f0", sum1); end
    total++; if (cout1 !== 1'b0) begin bad++; $display("FAIL sub1_cout got=%b want=0", cout1); end
    total++; if (ovf1 !== 1'b0) begin bad++; $display("FAIL sub1_ovf got=%b want=0", ovf1); end
    run1(8'h80, 8'h01, 1'b0, lat, nb, nd);
    total++; if (sum1 !== 8'h7F) begin bad++; $display("FAIL sub2_sum got=%h want=7f", sum1); end
    total++; if (cout1 !== 1'b1) begin bad++; $display("FAIL sub2_cout got=%b want=1", cout1); end
    total++; if (ovf1 !== 1'b1) begin bad++; $display("FAIL sub2_ovf got=%b want=1", ovf1); end
    sub = 1'b0;
  endtask
`endif

  initial begin
`ifdef SERIAL_ADDER_N_SUB_EN
    sub = 1'b0;
`endif
    test_reset();
    test_add_basic();
    test_carry();
    test_digit4();
    test_ignore_start();
    test_reset_abort();
`ifdef SERIAL_ADDER_N_SUB_EN
    test_sub();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "time limit reached");
  end

endmodule
